// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input, one valid strobe per period.
// Define PWM_CAP_DEGLITCH_EN to insert a FILT_LEN-cycle stability filter ahead of the edge detector.
module pwm_capture #(
  parameter int CNT_W = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF,
  parameter int FILT_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] period_cycles,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level,
  output logic             locked
);
`ifdef PWM_CAP_DEGLITCH_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state;
  logic meta, s, s_d, filt, f, rise, fall;
  logic [3:0] run;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  always_ff @(posedge clk)
    if (reset) {meta, s, s_d} <= '0;
    else {meta, s, s_d} <= {pwm_in, meta, f};
  // filtered level follows s only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk)
    if (reset || !FILT || s == filt) begin
      filt <= reset || !FILT ? 1'b0 : filt;
      run <= '0;
    end else if (run == 4'(FILT_LEN - 1)) begin
      filt <= s;
      run <= '0;
    end else
      run <= run + 4'd1;
  assign f = FILT ? filt : s;
  assign rise = f & ~s_d;
  assign fall = ~f & s_d;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      period_cnt <= '0;
      high_cnt <= '0;
      high_cycles <= '0;
      period_cycles <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
      stuck_level <= 1'b0;
      locked <= 1'b0;
    end else begin
      valid <= 1'b0;
      timeout <= 1'b0;
      if (rise) begin
        if (state == LOW) begin
          high_cycles <= high_cnt;
          period_cycles <= period_cnt;
          valid <= 1'b1;
          locked <= 1'b1;
        end
        state <= HIGH;
        period_cnt <= ONE;
        high_cnt <= ONE;
      end else if (state != IDLE && period_cnt == TO) begin
        timeout <= 1'b1;
        stuck_level <= s;
        locked <= 1'b0;
        state <= IDLE;
      end else if (state == HIGH) begin
        period_cnt <= period_cnt + ONE;
        if (fall) state <= LOW;
        else high_cnt <= high_cnt + ONE;
      end else if (state == LOW)
        period_cnt <= period_cnt + ONE;
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus checked against an edge-list reference model of the capture rules.
module tb_pwm_capture;
  localparam int T1 = 200, T2 = 100, FL = 4;
`ifdef PWM_CAP_DEGLITCH_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  typedef struct packed {logic to; logic lvl; logic [15:0] hi; logic [15:0] per; logic [31:0] cyc;} ev_t;
  logic clk = 1'b0, reset = 1'b1, pwm_in = 1'b0;
  logic [15:0] hi1, per1, hi2, per2;
  logic v1, to1, st1, lk1, v2, to2, st2, lk2;
  int checks = 0, failures = 0, cyc = 0;
  bit both1, both2;
  bit lv[$];
  int cy[$];
  ev_t got1[$], got2[$], exp[$];
  bit exp_lk, exp_st;
  logic [15:0] exp_hi, exp_per;

  pwm_capture #(.CNT_W(16), .TIMEOUT(T1), .FILT_LEN(FL)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_cycles(hi1), .period_cycles(per1),
    .valid(v1), .timeout(to1), .stuck_level(st1), .locked(lk1));
  pwm_capture #(.CNT_W(16), .TIMEOUT(T2), .FILT_LEN(FL)) dut2 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_cycles(hi2), .period_cycles(per2),
    .valid(v2), .timeout(to2), .stuck_level(st2), .locked(lk2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (v1 || to1) got1.push_back({to1, to1 & st1, v1 ? hi1 : 16'd0, v1 ? per1 : 16'd0, 32'(cyc)});
    if (v2 || to2) got2.push_back({to2, to2 & st2, v2 ? hi2 : 16'd0, v2 ? per2 : 16'd0, 32'(cyc)});
    if (v1 && to1) both1 = 1'b1;
    if (v2 && to2) both2 = 1'b1;
  end

  task automatic drive(input bit l, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_in = l;
      lv.push_back(l);
      cy.push_back(cyc);
    end
  endtask

  task automatic period(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic clear();
    lv.delete();
    cy.delete();
    got1.delete();
    got2.delete();
    both1 = 1'b0;
    both2 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear();
  endtask

  // Every pin-level change surfaces three clocks later; a period runs from one rise to the next.
  task automatic model(input int t);
    bit fl, prev, cur;
    int run, r, f;
    fl = 1'b0; prev = 1'b0; run = 0; r = -1; f = -1;
    exp.delete();
    exp_lk = 1'b0; exp_st = 1'b0; exp_hi = '0; exp_per = '0;
    foreach (lv[i]) begin
      cur = FILTER ? fl : lv[i];
      run = (lv[i] != fl) ? run + 1 : 0;
      if (run == FL) begin fl = lv[i]; run = 0; end
      if (cur && !prev) begin
        if (r >= 0) begin
          exp_hi = 16'(f - r);
          exp_per = 16'(i - r);
          exp_lk = 1'b1;
          exp.push_back({1'b0, 1'b0, exp_hi, exp_per, 32'(cy[i] + 3)});
        end
        r = i;
        f = -1;
      end else if (r >= 0 && i - r == t) begin
        exp.push_back({1'b1, lv[i], 16'd0, 16'd0, 32'(cy[i] + 3)});
        exp_lk = 1'b0;
        exp_st = lv[i];
        r = -1;
      end else if (!cur && prev && r >= 0 && f < 0) f = i;
      prev = cur;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk) pwm_in = 1'($urandom);
    checks++; if (hi1 !== 16'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", hi1); end
    checks++; if (per1 !== 16'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", per1); end
    checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", v1); end
    checks++; if (to1 !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", to1); end
    checks++; if (st1 !== 1'b0) begin failures++; $display("FAIL reset_stuck got=%b exp=0", st1); end
    checks++; if (lk1 !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", lk1); end
  endtask

  task automatic test_basic();
    do_reset();
    repeat (4) period(50, 50);
    repeat (4) @(negedge clk);
    model(T1);
    checks++; if (got1.size() != exp.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", got1.size(), exp.size()); end
    foreach (exp[i]) if (i < got1.size()) begin
      checks++; if (got1[i] !== exp[i]) begin failures++; $display("FAIL basic_ev%0d got=%p exp=%p", i, got1[i], exp[i]); end
    end
    checks++; if ({hi1, per1, lk1} !== {16'd50, 16'd100, 1'b1}) begin failures++; $display("FAIL basic_out got=%0d/%0d/%b exp=50/100/1", hi1, per1, lk1); end
    checks++; if (both1) begin failures++; $display("FAIL basic_both got=1 exp=0"); end
  endtask

  task automatic test_duty_sweep();
    int h;
    do_reset();
    period(1, 99);
    period(99, 1);
    period(25, 75);
    repeat (6) begin
      h = $urandom_range(1, 120);
      period(h, $urandom_range(1, 150 - h));
    end
    drive(1'b1, 20);
    repeat (4) @(negedge clk);
    model(T1);
    checks++; if (got1.size() != exp.size()) begin failures++; $display("FAIL duty_count got=%0d exp=%0d", got1.size(), exp.size()); end
    foreach (exp[i]) if (i < got1.size()) begin
      checks++; if (got1[i] !== exp[i]) begin failures++; $display("FAIL duty_ev%0d got=%p exp=%p", i, got1[i], exp[i]); end
    end
    checks++; if ({hi1, per1, lk1, st1} !== {exp_hi, exp_per, exp_lk, exp_st}) begin failures++; $display("FAIL duty_out got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", hi1, per1, lk1, st1, exp_hi, exp_per, exp_lk, exp_st); end
    checks++; if (both1) begin failures++; $display("FAIL duty_both got=1 exp=0"); end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (2) period(50, 50);
    drive(1'b1, 210);
    drive(1'b0, 10);
    drive(1'b1, 10);
    drive(1'b0, 210);
    repeat (4) @(negedge clk);
    model(T1);
    checks++; if (got1.size() != exp.size()) begin failures++; $display("FAIL timeout_count got=%0d exp=%0d", got1.size(), exp.size()); end
    foreach (exp[i]) if (i < got1.size()) begin
      checks++; if (got1[i] !== exp[i]) begin failures++; $display("FAIL timeout_ev%0d got=%p exp=%p", i, got1[i], exp[i]); end
    end
    checks++; if ({hi1, per1, lk1, st1} !== {exp_hi, exp_per, exp_lk, exp_st}) begin failures++; $display("FAIL timeout_out got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", hi1, per1, lk1, st1, exp_hi, exp_per, exp_lk, exp_st); end
    checks++; if (both1) begin failures++; $display("FAIL timeout_both got=1 exp=0"); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    period(50, 50);
    drive(1'b1, 30);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({hi1, per1, v1, to1, st1, lk1} !== 36'd0) begin failures++; $display("FAIL midreset_out got=%0d/%0d/%b/%b/%b/%b exp=0", hi1, per1, v1, to1, st1, lk1); end
    clear();
    lv.push_back(1'b1);
    cy.push_back(cyc);
    drive(1'b1, 19);
    drive(1'b0, 50);
    period(50, 50);
    drive(1'b1, 20);
    repeat (4) @(negedge clk);
    model(T1);
    checks++; if (got1.size() == 0 || got1[got1.size() - 1] !== exp[exp.size() - 1]) begin failures++; $display("FAIL midreset_last got_n=%0d exp=%p", got1.size(), exp[exp.size() - 1]); end
    checks++; if ({hi1, per1, lk1} !== {16'd50, 16'd100, 1'b1}) begin failures++; $display("FAIL midreset_final got=%0d/%0d/%b exp=50/100/1", hi1, per1, lk1); end
  endtask

  task automatic test_glitch();
    int a;
    do_reset();
    a = $urandom_range(5, 40);
    repeat (2) begin
      drive(1'b1, a);
      drive(1'b0, 2);
      drive(1'b1, 48 - a);
      drive(1'b0, 50);
    end
    drive(1'b1, 20);
    repeat (4) @(negedge clk);
    model(T1);
    checks++; if (got1.size() != exp.size()) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", got1.size(), exp.size()); end
    foreach (exp[i]) if (i < got1.size()) begin
      checks++; if (got1[i] !== exp[i]) begin failures++; $display("FAIL glitch_ev%0d got=%p exp=%p", i, got1[i], exp[i]); end
    end
    checks++; if ({hi1, per1, lk1} !== {exp_hi, exp_per, exp_lk}) begin failures++; $display("FAIL glitch_out got=%0d/%0d/%b exp=%0d/%0d/%b", hi1, per1, lk1, exp_hi, exp_per, exp_lk); end
  endtask

  task automatic test_boundary();
    do_reset();
    period(50, 50);
    period(50, 50);
    period(40, 61);
    period(30, 70);
    period(50, 50);
    drive(1'b1, 20);
    repeat (4) @(negedge clk);
    model(T2);
    checks++; if (got2.size() != exp.size()) begin failures++; $display("FAIL bound_count got=%0d exp=%0d", got2.size(), exp.size()); end
    foreach (exp[i]) if (i < got2.size()) begin
      checks++; if (got2[i] !== exp[i]) begin failures++; $display("FAIL bound_ev%0d got=%p exp=%p", i, got2[i], exp[i]); end
    end
    checks++; if ({hi2, per2, lk2, st2} !== {exp_hi, exp_per, exp_lk, exp_st}) begin failures++; $display("FAIL bound_out got=%0d/%0d/%b/%b exp=%0d/%0d/%b/%b", hi2, per2, lk2, st2, exp_hi, exp_per, exp_lk, exp_st); end
    checks++; if (both2) begin failures++; $display("FAIL bound_both got=1 exp=0"); end
    model(T1);
    checks++; if (got1.size() != exp.size()) begin failures++; $display("FAIL bound_wide_count got=%0d exp=%0d", got1.size(), exp.size()); end
    foreach (exp[i]) if (i < got1.size()) begin
      checks++; if (got1[i] !== exp[i]) begin failures++; $display("FAIL bound_wide_ev%0d got=%p exp=%p", i, got1[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_sweep();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
